dst_out_fifo: RTL and testbench

- Output staging FIFO between the accelerator's result path (dst_valid/dst_data from the batch controller and dst buffer) and the external output stream/DMA.
- Absorbs downstream back-pressure and counts words per batch so that a valid stream last flag is generated on the final word.
- Reports occupancy, busy and a one-cycle done pulse to the sequencer.

---
 rtl/dst_out_fifo.sv | 78 +++++++
 tb/tb_dst_out_fifo.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dst_out_fifo.sv
// dst_out_fifo: output staging FIFO that tags the final word of each batch and pulses done when it drains.
// Define DST_OUT_RELU_EN to clamp negative fp32 words to +0.0 on the write path.
module dst_out_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int CW    = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CW-1:0]              ds,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW:0]   mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic [CW-1:0] len_q, cnt_q;
  logic          busy_q, in_done_q, done_q;
  logic          push, pop;
  logic [DW:0]   head;
  logic [DW-1:0] wdata;
  // level never exceeds DEPTH, so its top bit alone marks full
  assign level     = wr_q - rd_q;
  assign in_ready  = busy_q & ~level[AW] & ~in_done_q;
  assign out_valid = wr_q != rd_q;
  assign head      = mem_q[rd_q[AW-1:0]];
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid & head[DW];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DST_OUT_RELU_EN
  assign wdata = in_data[DW-1] ? '0 : in_data;
`else
  assign wdata = in_data;
`endif
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {cnt_q == len_q, wdata};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      in_done_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= pop & head[DW];
      if (push) begin
        wr_q  <= wr_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == len_q) in_done_q <= 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (pop & head[DW]) begin
        busy_q    <= 1'b0;
        in_done_q <= 1'b0;
      end
      if (start & ~busy_q) begin
        len_q  <= ds;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dst_out_fifo.sv
// tb_dst_out_fifo: randomized bench checking dst_out_fifo cycle by cycle against a queue-based batch model.
module tb_dst_out_fifo;
  localparam int DEPTH = 8, DW = 32, CW = 12;
  logic clk = 1'b0, rst_n;
  logic start, in_valid, in_ready, out_valid, out_last, out_ready, busy, done;
  logic [CW-1:0] ds;
  logic [DW-1:0] in_data, out_data;
  logic [$clog2(DEPTH):0] level;
  int checks = 0, errors = 0;
  logic [32:0] mq[$];
  logic [31:0] src[$];
  bit m_busy, m_done, m_in_done;
  int m_len, m_cnt;

  dst_out_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ds(ds),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef DST_OUT_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    m_busy = 0; m_done = 0; m_in_done = 0; m_len = 0; m_cnt = 0;
  endtask

  // one clock cycle: drive, compare against the model, then advance the model past the edge
  task automatic cycle(input bit st, input int d, input bit iv, input bit ordy);
    logic [31:0] w;
    logic [32:0] h;
    bit e_ir, push, pop, ob;
    w = (m_cnt < src.size()) ? src[m_cnt] : $urandom;
    start = st; ds = d[CW-1:0]; in_valid = iv; in_data = w; out_ready = ordy;
    #1;
    e_ir = m_busy && mq.size() < DEPTH && !m_in_done;
    h = (mq.size() > 0) ? mq[0] : 33'd0;
    check("in_ready", in_ready, e_ir);
    check("out_valid", out_valid, mq.size() > 0);
    check("out_data", out_data, h[31:0]);
    check("out_last", out_last, h[32]);
    check("level", level, mq.size());
    check("busy", busy, m_busy);
    check("done", done, m_done);
    push = iv && e_ir;
    pop = ordy && mq.size() > 0;
    ob = m_busy;
    @(posedge clk); #1;
    m_done = 0;
    if (pop) begin
      h = mq.pop_front();
      if (h[32]) begin m_done = 1; m_busy = 0; m_in_done = 0; end
    end
    if (push) begin
      mq.push_back({m_cnt == m_len, relu(w)});
      if (m_cnt == m_len) m_in_done = 1;
      m_cnt++;
    end
    if (st && !ob) begin m_len = d; m_cnt = 0; m_busy = 1; end
  endtask

  // random traffic with stray start pulses until the batch completes or the budget runs out
  task automatic drain(input int pv, input int pr, input int budget);
    for (int i = 0; i < budget && !m_done; i++)
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 4095),
            $urandom_range(1, 100) <= pv, $urandom_range(1, 100) <= pr);
    check("batch_idle", busy, 0);
  endtask

  task automatic run(input int d, input int pv, input int pr, input int budget);
    cycle(1, d, 0, 0);
    drain(pv, pr, budget);
  endtask

  initial begin
    rst_n = 0; start = 0; ds = '0; in_valid = 0; in_data = '0; out_ready = 0;
    model_clear();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    src = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    run(3, 100, 100, 50);

    src.delete();
    cycle(1, 15, 0, 0);
    repeat (10) cycle(0, 15, 1, 0);
    check("full_level", level, DEPTH);
    check("full_in_ready", in_ready, 0);
    drain(100, 100, 100);

    src = '{32'hC0000000};
    run(0, 100, 100, 50);
    src = '{32'h80000000};
    run(0, 100, 100, 50);

    src.delete();
    run(63, 70, 50, 1000);
    for (int k = 0; k < 6; k++) run($urandom_range(0, 40), 60, 60, 1000);
    run(4095, 95, 95, 10000);

    cycle(1, 20, 0, 0);
    repeat (5) cycle(0, 20, 1, 0);
    check("pre_rst_level", level, 5);
    #2 rst_n = 0;
    #1;
    model_clear();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_level", level, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    run(1, 100, 100, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
